// File: rtl/fsm16_pkg.sv
// Shared constants for the 16-state controlled FSM: state codes, driver phases,
// successor tables and the input pairs that select each branch.
package fsm16_pkg;

    localparam logic [3:0] S0  = 4'd0,  S1  = 4'd1,  S2  = 4'd2,  S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4,  S5  = 4'd5,  S6  = 4'd6,  S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8,  S9  = 4'd9,  S10 = 4'd10, S11 = 4'd11;
    localparam logic [3:0] S12 = 4'd12, S13 = 4'd13, S14 = 4'd14, S15 = 4'd15;

    localparam logic BR_A = 1'b0;
    localparam logic BR_B = 1'b1;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_PLAN  = 2'd1,
        PH_DRIVE = 2'd2,
        PH_DONE  = 2'd3
    } phase_t;

    // Indexed by k = state[2:0]; the upper state bit never affects the next hop.
    localparam logic [3:0] SUCC_A [8] = '{S1, S3, S5, S7, S9, S11, S13, S15};
    localparam logic [3:0] SUCC_B [8] = '{S2, S4, S6, S8, S10, S12, S14, S0};

    // Pair encoding: bit 1 = input1, bit 0 = input2.
    localparam logic [1:0] PAIR_A [8] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic [1:0] PAIR_B [8] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};

    function automatic logic [3:0] next_state(input logic [3:0] s, input logic br);
        return (br == BR_B) ? SUCC_B[s[2:0]] : SUCC_A[s[2:0]];
    endfunction

    function automatic logic [1:0] drive_pair(input logic [3:0] s, input logic br);
        return (br == BR_B) ? PAIR_B[s[2:0]] : PAIR_A[s[2:0]];
    endfunction

endpackage

// File: rtl/fsm16_stim_driver_if.sv
// Target-request and stimulus bus of the stimulus driver.
// FSM16_DRV_MON_EN adds the dut_state feedback and the sticky mismatch flag.
interface fsm16_stim_driver_if;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_state;
    logic       drv_input1;
    logic       drv_input2;
    logic       drv_valid;
    logic [3:0] model_state;
    logic       done;
    logic [2:0] steps;
`ifdef FSM16_DRV_MON_EN
    logic [3:0] dut_state;
    logic       mismatch;

    modport master (output tgt_valid, tgt_state, dut_state,
                    input  tgt_ready, drv_input1, drv_input2, drv_valid,
                           model_state, done, steps, mismatch);
    modport slave  (input  tgt_valid, tgt_state, dut_state,
                    output tgt_ready, drv_input1, drv_input2, drv_valid,
                           model_state, done, steps, mismatch);
`else
    modport master (output tgt_valid, tgt_state,
                    input  tgt_ready, drv_input1, drv_input2, drv_valid,
                           model_state, done, steps);
    modport slave  (input  tgt_valid, tgt_state,
                    output tgt_ready, drv_input1, drv_input2, drv_valid,
                           model_state, done, steps);
`endif
endinterface

// File: rtl/fsm16_route.sv
// Combinational shortest-route finder: branch bits (first hop in bit 0, 1 = B)
// and hop count from cur_state to tgt_state, at most 4 hops.
module fsm16_route
    import fsm16_pkg::*;
(
    input  logic [3:0] cur_state,
    input  logic [3:0] tgt_state,
    output logic [2:0] path_len,
    output logic [3:0] path_bits
);

    logic       found;
    logic [3:0] walk;
    logic [3:0] pat;

    // Lengths are tried shortest first; each length has at most one hit.
    always_comb begin
        path_len  = 3'd0;
        path_bits = 4'd0;
        found     = (cur_state == tgt_state);
        walk      = cur_state;
        pat       = 4'd0;
        for (int n = 1; n <= 4; n++) begin
            for (int p = 0; p < 16; p++) begin
                pat  = 4'(p);
                walk = cur_state;
                for (int h = 0; h < 4; h++) begin
                    if (h < n) walk = next_state(walk, pat[h]);
                end
                if (!found && (p < (1 << n)) && (walk == tgt_state)) begin
                    found     = 1'b1;
                    path_len  = 3'(n);
                    path_bits = pat;
                end
            end
        end
    end

endmodule

// File: rtl/fsm16_stim_driver.sv
// Steers a 16-state FSM to a requested state by replaying the shortest branch
// sequence; FSM16_DRV_MON_EN adds a sticky check of dut_state against the mirror.
module fsm16_stim_driver
    import fsm16_pkg::*;
(
    input logic                clk,
    input logic                reset,
    fsm16_stim_driver_if.slave bus
);

    phase_t     phase_q, phase_d;
    logic [3:0] model_state_q, model_state_d;
    logic [3:0] target_q, target_d;
    logic [2:0] steps_q, steps_d;
    logic [2:0] hops_q, hops_d;
    logic [3:0] bits_q, bits_d;
    logic [1:0] pair_q, pair_d;
    logic       drv_valid_q, drv_valid_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;
    logic [3:0] hop_state;
    logic [2:0] route_len;
    logic [3:0] route_bits;

    fsm16_route u_route (
        .cur_state (model_state_q),
        .tgt_state (target_q),
        .path_len  (route_len),
        .path_bits (route_bits)
    );

    // Stimulus outputs are computed one cycle ahead so they leave straight from flops.
    always_comb begin
        phase_d       = phase_q;
        model_state_d = model_state_q;
        target_d      = target_q;
        steps_d       = steps_q;
        hops_d        = hops_q;
        bits_d        = bits_q;
        pair_d        = 2'b00;
        drv_valid_d   = 1'b0;
        done_d        = 1'b0;
        hop_state     = next_state(model_state_q, bits_q[0]);
        case (phase_q)
            PH_IDLE: begin
                if (bus.tgt_valid && ready_q) begin
                    target_d = bus.tgt_state;
                    phase_d  = PH_PLAN;
                end
            end
            PH_PLAN: begin
                steps_d = route_len;
                hops_d  = route_len;
                bits_d  = route_bits;
                if (route_len == 3'd0) begin
                    phase_d = PH_DONE;
                    done_d  = 1'b1;
                end else begin
                    phase_d     = PH_DRIVE;
                    drv_valid_d = 1'b1;
                    pair_d      = drive_pair(model_state_q, route_bits[0]);
                end
            end
            PH_DRIVE: begin
                model_state_d = hop_state;
                bits_d        = {1'b0, bits_q[3:1]};
                hops_d        = hops_q - 3'd1;
                if (hops_q == 3'd1) begin
                    phase_d = PH_DONE;
                    done_d  = 1'b1;
                end else begin
                    drv_valid_d = 1'b1;
                    pair_d      = drive_pair(hop_state, bits_q[1]);
                end
            end
            default: phase_d = PH_IDLE;
        endcase
        ready_d = (phase_d == PH_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= PH_IDLE;
            model_state_q <= S0;
            target_q      <= S0;
            steps_q       <= 3'd0;
            hops_q        <= 3'd0;
            bits_q        <= 4'd0;
            pair_q        <= 2'b00;
            drv_valid_q   <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            phase_q       <= phase_d;
            model_state_q <= model_state_d;
            target_q      <= target_d;
            steps_q       <= steps_d;
            hops_q        <= hops_d;
            bits_q        <= bits_d;
            pair_q        <= pair_d;
            drv_valid_q   <= drv_valid_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
        end
    end

    assign bus.tgt_ready   = ready_q;
    assign bus.drv_input1  = pair_q[1];
    assign bus.drv_input2  = pair_q[0];
    assign bus.drv_valid   = drv_valid_q;
    assign bus.model_state = model_state_q;
    assign bus.done        = done_q;
    assign bus.steps       = steps_q;

`ifdef FSM16_DRV_MON_EN
    logic check_q, check_d;
    logic mismatch_q, mismatch_d;

    // The controlled FSM has taken the step by the cycle after drv_valid.
    always_comb begin
        check_d    = drv_valid_q;
        mismatch_d = mismatch_q | (check_q && (bus.dut_state != model_state_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            check_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            check_q    <= check_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_fsm16_stim_driver.sv
// Directed bench for fsm16_stim_driver; the FSM16_DRV_MON_EN section runs only
// when the monitor is compiled in.
module tb_fsm16_stim_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [1:0] exp_pair [4] = '{2'b11, 2'b01, 2'b00, 2'b00};
    logic [3:0] exp_src  [4] = '{4'd0, 4'd1, 4'd3, 4'd7};

    always #5 clk = ~clk;

    fsm16_stim_driver_if bus ();

    fsm16_stim_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // One-cycle request; returns in the cycle after acceptance (PLAN).
    task automatic request(input logic [3:0] t);
        $display("request target S%0d at %0t", t, $time);
        bus.tgt_valid = 1'b1;
        bus.tgt_state = t;
        tick(1);
        bus.tgt_valid = 1'b0;
    endtask

    initial begin
        bus.tgt_valid = 1'b0;
        bus.tgt_state = 4'd0;
`ifdef FSM16_DRV_MON_EN
        bus.dut_state = 4'd0;
`endif
        do_reset();

        check("rst_ready", 8'(bus.tgt_ready), 8'd1);
        check("rst_done", 8'(bus.done), 8'd0);
        check("rst_drv_valid", 8'(bus.drv_valid), 8'd0);
        check("rst_inputs", 8'({bus.drv_input1, bus.drv_input2}), 8'd0);
        check("rst_steps", 8'(bus.steps), 8'd0);
        check("rst_model", 8'(bus.model_state), 8'd0);

        // S0 -> S0: zero hops, done two cycles after acceptance
        request(4'd0);
        check("t0_plan_done", 8'(bus.done), 8'd0);
        check("t0_plan_ready", 8'(bus.tgt_ready), 8'd0);
        check("t0_plan_drv", 8'(bus.drv_valid), 8'd0);
        tick(1);
        check("t0_done", 8'(bus.done), 8'd1);
        check("t0_steps", 8'(bus.steps), 8'd0);
        check("t0_model", 8'(bus.model_state), 8'd0);
        check("t0_drv", 8'(bus.drv_valid), 8'd0);
        tick(1);
        check("t0_idle_done", 8'(bus.done), 8'd0);
        check("t0_idle_ready", 8'(bus.tgt_ready), 8'd1);

        // S0 -> S2: one B hop with pair (0,0)
        request(4'd2);
        check("t2_plan_drv", 8'(bus.drv_valid), 8'd0);
        tick(1);
        check("t2_drv", 8'(bus.drv_valid), 8'd1);
        check("t2_pair", 8'({bus.drv_input1, bus.drv_input2}), 8'b00);
        check("t2_steps", 8'(bus.steps), 8'd1);
        check("t2_done_early", 8'(bus.done), 8'd0);
        tick(1);
        check("t2_done", 8'(bus.done), 8'd1);
        check("t2_model", 8'(bus.model_state), 8'd2);
        check("t2_drv_off", 8'(bus.drv_valid), 8'd0);
        tick(1);

        // S0 -> S15: four A hops
        do_reset();
        request(4'd15);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t15_drv%0d", i), 8'(bus.drv_valid), 8'd1);
            check($sformatf("t15_pair%0d", i), 8'({bus.drv_input1, bus.drv_input2}), 8'(exp_pair[i]));
            check($sformatf("t15_src%0d", i), 8'(bus.model_state), 8'(exp_src[i]));
            check($sformatf("t15_nodone%0d", i), 8'(bus.done), 8'd0);
            tick(1);
        end
        check("t15_done", 8'(bus.done), 8'd1);
        check("t15_model", 8'(bus.model_state), 8'd15);
        check("t15_steps", 8'(bus.steps), 8'd4);
        check("t15_drv_off", 8'(bus.drv_valid), 8'd0);
        tick(1);

        // S15 -> S0: wrap-around via branch B at k=7, pair (1,1)
        request(4'd0);
        tick(1);
        check("wrap_drv", 8'(bus.drv_valid), 8'd1);
        check("wrap_pair", 8'({bus.drv_input1, bus.drv_input2}), 8'b11);
        tick(1);
        check("wrap_done", 8'(bus.done), 8'd1);
        check("wrap_model", 8'(bus.model_state), 8'd0);
        check("wrap_steps", 8'(bus.steps), 8'd1);
        tick(1);

        // Reset during the second DRIVE cycle of the S15 route
        request(4'd15);
        tick(2);
        check("abort_in_drive", 8'(bus.drv_valid), 8'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("abort_model", 8'(bus.model_state), 8'd0);
        check("abort_ready", 8'(bus.tgt_ready), 8'd1);
        check("abort_drv", 8'(bus.drv_valid), 8'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("abort_nodone%0d", i), 8'(bus.done), 8'd0);
            tick(1);
        end

        // tgt_valid held high: S2 taken first, S1 only after DONE (S2 -> S1 is A,A,B,A)
        $display("request target S2 held valid, then S1 at %0t", $time);
        bus.tgt_valid = 1'b1;
        bus.tgt_state = 4'd2;
        tick(1);
        bus.tgt_state = 4'd1;
        check("hold_ready1", 8'(bus.tgt_ready), 8'd0);
        tick(1);
        check("hold_ready2", 8'(bus.tgt_ready), 8'd0);
        check("hold_drv", 8'(bus.drv_valid), 8'd1);
        tick(1);
        check("hold_done", 8'(bus.done), 8'd1);
        check("hold_model", 8'(bus.model_state), 8'd2);
        check("hold_ready3", 8'(bus.tgt_ready), 8'd0);
        tick(1);
        check("hold_idle_ready", 8'(bus.tgt_ready), 8'd1);
        tick(1);
        bus.tgt_valid = 1'b0;
        check("hold_second_plan", 8'(bus.tgt_ready), 8'd0);
        tick(1);
        check("hold_second_pair", 8'({bus.drv_input1, bus.drv_input2}), 8'b10);
        tick(3);
        check("hold_second_nodone", 8'(bus.done), 8'd0);
        tick(1);
        check("hold_second_done", 8'(bus.done), 8'd1);
        check("hold_second_model", 8'(bus.model_state), 8'd1);
        check("hold_second_steps", 8'(bus.steps), 8'd4);
        tick(1);

`ifdef FSM16_DRV_MON_EN
        // Controlled FSM reports S4 instead of S1 after the first S15 step
        bus.dut_state = 4'd0;
        do_reset();
        check("mon_rst", 8'(bus.mismatch), 8'd0);
        request(4'd15);
        tick(1);
        check("mon_clean", 8'(bus.mismatch), 8'd0);
        tick(1);
        bus.dut_state = 4'd4;
        tick(1);
        check("mon_set", 8'(bus.mismatch), 8'd1);
        tick(4);
        check("mon_sticky", 8'(bus.mismatch), 8'd1);
        bus.dut_state = 4'd0;
        do_reset();
        check("mon_cleared", 8'(bus.mismatch), 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
